rca8_sum_accumulator: RTL and testbench



---
 rtl/rca8_sum_accumulator.sv | 142 ++++++++++++++
 tb/tb_rca8_sum_accumulator.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/rca8_sum_accumulator.sv
// rca8_sum_accumulator
//   Reduces a fixed-length frame of COUNT adder sums, arriving on a
//   valid/ready stream, into one wider total. Each total is presented on a
//   registered valid/ready output. A completed total may replace a draining
//   one in the same cycle, so the adder can run back-to-back without
//   bubbles; input is held off only when a frame would complete while the
//   previous total is still waiting.
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   clear       synchronous flush of the partial frame and any pending total
//   in_valid    in_sum is valid this cycle
//   in_ready    block accepts in_sum this cycle (combinational)
//   in_sum      unsigned sum from the adder, carry bit included
//   out_valid   out_acc holds a completed frame total
//   out_ready   downstream accepts out_acc
//   out_acc     unsigned frame total
//   out_frames  frames delivered (output handshakes), wraps 255 -> 0
//
// state | meaning
// IDLE  | no sums of the current frame accepted yet (cnt == 0, acc == 0)
// ACCUM | frame in progress (0 < cnt < COUNT)
// STALL | last sum of the frame is due but the previous total is unread
module rca8_sum_accumulator #(
  parameter int IN_W  = 9,
  parameter int COUNT = 4,
  parameter int ACC_W = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic [7:0]       out_frames
);

  localparam int CNT_W = $clog2(COUNT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(COUNT - 1);

  if (COUNT < 2 || COUNT > 256) begin : g_bad_count
    $error("rca8_sum_accumulator: COUNT must be in 2..256");
  end
  if (ACC_W < IN_W + $clog2(COUNT)) begin : g_bad_acc_w
    $error("rca8_sum_accumulator: ACC_W too narrow, frame total could overflow");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    STALL = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [ACC_W-1:0] acc, acc_nxt;
  logic [ACC_W-1:0] out_acc_nxt;
  logic             out_valid_nxt;
  logic [7:0]       out_frames_nxt;

  logic             frame_last;
  logic             in_fire;
  logic             out_fire;
  logic [ACC_W-1:0] acc_sum;

  // State register and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      acc        <= '0;
      out_acc    <= '0;
      out_valid  <= 1'b0;
      out_frames <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      acc        <= acc_nxt;
      out_acc    <= out_acc_nxt;
      out_valid  <= out_valid_nxt;
      out_frames <= out_frames_nxt;
    end
  end

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;
  assign acc_sum  = acc + ACC_W'(in_sum);

  // Next-state and next-datapath logic
  always_comb begin
    cnt_nxt        = cnt;
    acc_nxt        = acc;
    out_acc_nxt    = out_acc;
    out_valid_nxt  = out_valid;
    out_frames_nxt = out_frames;

    if (clear) begin
      // Discards the partial frame and any pending total; the delivered
      // frame count is history and survives.
      cnt_nxt       = '0;
      acc_nxt       = '0;
      out_valid_nxt = 1'b0;
    end else begin
      if (out_fire) begin
        out_valid_nxt  = 1'b0;
        out_frames_nxt = out_frames + 8'd1;
      end
      if (in_fire) begin
        if (frame_last) begin
          // Overrides the drain above: zero-bubble handoff when both fire.
          out_acc_nxt   = acc_sum;
          out_valid_nxt = 1'b1;
          acc_nxt       = '0;
          cnt_nxt       = '0;
        end else begin
          acc_nxt = acc_sum;
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
    end

    if (cnt_nxt == '0) begin
      state_nxt = IDLE;
    end else if (cnt_nxt == LAST && out_valid_nxt && !out_ready) begin
      state_nxt = STALL;
    end else begin
      state_nxt = ACCUM;
    end
  end

  // Output logic: input is held off only when accepting would complete a
  // frame while the previous total is still unread.
  always_comb begin
    frame_last = (state != IDLE) && (cnt == LAST);
    in_ready   = !clear && !(frame_last && out_valid && !out_ready);
  end

endmodule

// File: tb/tb_rca8_sum_accumulator.sv
module tb_rca8_sum_accumulator;

  localparam int IN_W  = 9;
  localparam int COUNT = 4;
  localparam int ACC_W = 11;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             clear = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [IN_W-1:0]  in_sum = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [ACC_W-1:0] out_acc;
  logic [7:0]       out_frames;

  int checks = 0;
  int failures = 0;

  rca8_sum_accumulator #(.IN_W(IN_W), .COUNT(COUNT), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_sum(in_sum),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_acc(out_acc), .out_frames(out_frames)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Behavioural model: accepted sums are queued; a full queue becomes one total.
  int q[$];
  int m_valid = 0;
  int m_acc = 0;
  int m_frames = 0;

  function automatic int m_in_ready();
    return (!clear && !(q.size() == COUNT - 1 && m_valid != 0 && !out_ready)) ? 1 : 0;
  endfunction

  always @(negedge rst_n) begin
    q.delete();
    m_valid = 0;
    m_acc = 0;
    m_frames = 0;
  end

  always @(posedge clk) begin
    if (rst_n) begin
      if (clear) begin
        q.delete();
        m_valid = 0;
      end else begin
        int fire_in, fire_out, tot;
        fire_in  = (in_valid && m_in_ready() != 0) ? 1 : 0;
        fire_out = (m_valid != 0 && out_ready) ? 1 : 0;
        if (fire_out != 0) begin
          m_valid = 0;
          m_frames = (m_frames + 1) % 256;
        end
        if (fire_in != 0) begin
          q.push_back(int'(in_sum));
          if (q.size() == COUNT) begin
            tot = 0;
            foreach (q[i]) tot += q[i];
            m_acc = tot;
            m_valid = 1;
            q.delete();
          end
        end
      end
    end
  end

  // Cycle-by-cycle compare against the model
  always @(negedge clk) begin
    check("in_ready", int'(in_ready), m_in_ready());
    check("out_valid", int'(out_valid), m_valid);
    check("out_frames", int'(out_frames), m_frames);
    if (m_valid != 0) check("out_acc", int'(out_acc), m_acc);
  end

  // Drive one sum and hold it until accepted; returns cycles taken.
  task automatic send(input int v, output int cycles);
    bit ok;
    in_valid = 1'b1;
    in_sum = IN_W'(v);
    ok = 0;
    cycles = 0;
    while (!ok && cycles < 50) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      cycles++;
    end
    if (!ok) begin
      failures++;
      $display("FAIL send_timeout: sum %0d not accepted after %0d cycles", v, cycles);
    end
    in_valid = 1'b0;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int c, total;
    reset_dut();
    check("reset_in_ready", int'(in_ready), 1);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_out_acc", int'(out_acc), 0);
    check("reset_out_frames", int'(out_frames), 0);

    // Basic frame
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) send(i, c);
    check("basic_valid", int'(out_valid), 1);
    check("basic_acc", int'(out_acc), 10);
    @(posedge clk); #1;
    check("basic_frames", int'(out_frames), 1);
    check("basic_drained", int'(out_valid), 0);

    // Max values
    for (int i = 0; i < 4; i++) send(511, c);
    check("max_acc", int'(out_acc), 2044);
    @(posedge clk); #1;

    // Backpressure
    reset_dut();
    out_ready = 1'b0;
    for (int i = 1; i <= 7; i++) send(i, c);
    in_valid = 1'b1;
    in_sum = IN_W'(8);
    @(negedge clk);
    check("bp_in_ready_low", int'(in_ready), 0);
    check("bp_acc_held", int'(out_acc), 10);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("bp_acc_stable", int'(out_acc), 10);
    check("bp_still_blocked", int'(in_ready), 0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid = 1'b0;
    check("bp_second_valid", int'(out_valid), 1);
    check("bp_second_acc", int'(out_acc), 26);
    check("bp_frames_after_drain", int'(out_frames), 1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_frames_final", int'(out_frames), 2);

    // Zero-bubble
    reset_dut();
    out_ready = 1'b1;
    total = 0;
    for (int i = 0; i < 12; i++) begin
      send(5, c);
      total += c;
      if (i % 4 == 3) begin
        check("zb_valid", int'(out_valid), 1);
        check("zb_acc", int'(out_acc), 20);
      end
    end
    check("zb_no_stall_cycles", total, 12);
    @(posedge clk); #1;
    check("zb_frames", int'(out_frames), 3);

    // Async reset mid-frame
    send(7, c);
    send(7, c);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", int'(out_valid), 0);
    check("arst_out_acc", int'(out_acc), 0);
    check("arst_out_frames", int'(out_frames), 0);
    check("arst_in_ready", int'(in_ready), 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) send(1, c);
    check("arst_next_total", int'(out_acc), 4);
    @(posedge clk); #1;

    // clear
    reset_dut();
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) send(i, c);
    send(1, c);
    send(1, c);
    clear = 1'b1;
    in_valid = 1'b1;
    in_sum = IN_W'(9);
    @(negedge clk);
    check("clr_in_ready", int'(in_ready), 0);
    @(posedge clk); #1;
    clear = 1'b0;
    in_valid = 1'b0;
    check("clr_out_valid", int'(out_valid), 0);
    check("clr_frames_kept", int'(out_frames), 0);
    for (int i = 0; i < 4; i++) send(2, c);
    check("clr_next_valid", int'(out_valid), 1);
    check("clr_next_total", int'(out_acc), 8);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("clr_frames_after", int'(out_frames), 1);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
